logic_unit_mc: RTL and testbench



---
 rtl/logic_unit_pkg.sv | 26 ++
 rtl/logic_slice.sv | 28 ++
 rtl/logic_unit_mc.sv | 109 ++++++++++
 tb/tb_logic_unit_mc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode and FSM state definitions for the multi-cycle bitwise logic unit.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Slice counter needs at least one bit even when the word is a single slice.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/logic_slice.sv
// Combinational CHUNK-wide bitwise operator, reused for every slice of the word.
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int unsigned CHUNK = 8
) (
    input  op_e              op,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [CHUNK-1:0] y
);

    always_comb begin
        y = a;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_PASS: y = a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_mc.sv
// Multi-cycle bitwise logic unit: captures a request, evaluates it one CHUNK slice
// per cycle (LSB first) and holds the result behind a valid/ready output handshake.
module logic_unit_mc
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = cnt_width(N);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("logic_unit_mc: CHUNK must divide WIDTH");
    end

    state_e                      state_q, state_d;
    op_e                         op_q, op_d;
    logic [N-1:0][CHUNK-1:0]     a_q, a_d;
    logic [N-1:0][CHUNK-1:0]     b_q, b_d;
    logic [N-1:0][CHUNK-1:0]     result_q, result_d;
    logic                        zero_q, zero_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [CHUNK-1:0]            slice_y;

    logic_slice #(.CHUNK(CHUNK)) u_slice (
        .op (op_q),
        .a  (a_q[cnt_q]),
        .b  (b_q[cnt_q]),
        .y  (slice_y)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d     = op_e'(op);
                    a_d      = data_a;
                    b_d      = data_b;
                    result_d = '0;
                    zero_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                result_d[cnt_q] = slice_y;
                zero_d          = zero_q & (slice_y == '0);
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NOT;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_logic_unit_mc.sv
// Randomized and directed checks of logic_unit_mc across four WIDTH/CHUNK builds.
module tb_logic_unit_mc;

    logic        clk;
    logic        rst_n;
    logic [3:0]  iv;
    logic [3:0]  ir;
    logic [3:0]  ov;
    logic [3:0]  ordy;
    logic [3:0]  z;
    logic [2:0]  op_s;
    logic [63:0] da;
    logic [63:0] db;
    logic [63:0] res [4];

    int unsigned checks = 0;
    int unsigned errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned W = (g == 3) ? 64 : 32;
        localparam int unsigned C = (g == 0) ? 8 : (g == 1) ? 32 : (g == 2) ? 1 : 16;
        logic [W-1:0] r;
        logic_unit_mc #(.WIDTH(W), .CHUNK(C)) dut (
            .clock     (clk),
            .reset_n   (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .op        (op_s),
            .data_a    (da[W-1:0]),
            .data_b    (db[W-1:0]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .result    (r),
            .zero      (z[g])
        );
        assign res[g] = 64'(r);
    end

    function automatic int unsigned cfg_w(input int unsigned k);
        return (k == 3) ? 64 : 32;
    endfunction

    function automatic int unsigned cfg_n(input int unsigned k);
        int unsigned c;
        c = (k == 0) ? 8 : (k == 1) ? 32 : (k == 2) ? 1 : 16;
        return cfg_w(k) / c;
    endfunction

    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] a,
                                           input logic [63:0] b, input int unsigned w);
        logic [63:0] r;
        logic [63:0] m;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        case (o)
            3'd0:    r = ~a;
            3'd1:    r = a & b;
            3'd2:    r = a | b;
            3'd3:    r = a ^ b;
            3'd4:    r = ~(a & b);
            3'd5:    r = ~(a | b);
            3'd6:    r = ~(a ^ b);
            default: r = a;
        endcase
        return r & m;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with unit k idle. Operands are scrambled right after accept.
    task automatic do_op(input int unsigned k, input logic [2:0] o, input logic [63:0] a,
                         input logic [63:0] b, input int unsigned hold, input bit stray);
        int unsigned n;
        int unsigned lat;
        logic [63:0] exp;
        n   = cfg_n(k);
        exp = ref_op(o, a, b, cfg_w(k));
        check("ready_before", 64'(ir[k]), 64'd1);
        op_s    = o;
        da      = a;
        db      = b;
        iv[k]   = 1'b1;
        ordy[k] = 1'b0;
        @(posedge clk); #1;
        iv[k] = 1'b0;
        da    = '1;
        db    = '1;
        op_s  = 3'($urandom);
        lat   = 0;
        while (!ov[k] && lat < n + 20) begin
            check("busy_in_ready", 64'(ir[k]), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(n));
        check("done_in_ready", 64'(ir[k]), 64'd0);
        check("result", res[k], exp);
        check("zero", 64'(z[k]), 64'(exp == 64'd0));
        for (int unsigned h = 0; h < hold; h++) begin
            if (stray) begin
                iv[k] = 1'b1;
                op_s  = 3'($urandom);
            end
            @(posedge clk); #1;
            iv[k] = 1'b0;
            check("hold_valid", 64'(ov[k]), 64'd1);
            check("hold_result", res[k], exp);
        end
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        check("released_valid", 64'(ov[k]), 64'd0);
        check("ready_after", 64'(ir[k]), 64'd1);
        check("idle_result", res[k], exp);
        check("idle_zero", 64'(z[k]), 64'(exp == 64'd0));
        if (stray) begin
            @(posedge clk); #1;
            check("no_queued_valid", 64'(ov[k]), 64'd0);
            check("no_queued_ready", 64'(ir[k]), 64'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        iv    = '0;
        ordy  = '0;
        op_s  = '0;
        da    = '0;
        db    = '0;
        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int unsigned k = 0; k < 4; k++) begin
            check("rst_in_ready", 64'(ir[k]), 64'd1);
            check("rst_out_valid", 64'(ov[k]), 64'd0);
            check("rst_result", res[k], 64'd0);
            check("rst_zero", 64'(z[k]), 64'd0);
        end

        do_op(0, 3'd0, 64'h0000_FFFF, 64'h1234_5678, 0, 1'b0);
        check("not_value", res[0], 64'hFFFF_0000);
        do_op(0, 3'd3, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 0, 1'b0);
        check("xor_zero", 64'(z[0]), 64'd1);
        do_op(0, 3'd4, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 1'b0);
        check("nand_zero", 64'(z[0]), 64'd1);
        do_op(0, 3'd1, 64'hF0F0_F0F0, 64'hFF00_FF00, 3, 1'b1);
        check("and_value", res[0], 64'hF000_F000);
        do_op(0, 3'd2, 64'h1234_0000, 64'h0000_5678, 0, 1'b0);
        check("or_value", res[0], 64'h1234_5678);

        // Asynchronous reset in the middle of slice 2 of an XNOR.
        op_s  = 3'd6;
        da    = 64'h1234_5678;
        db    = 64'h0;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("partial_result", res[0], 64'h0000_A987);
        #2 rst_n = 1'b0;
        #1;
        check("arst_result", res[0], 64'd0);
        check("arst_zero", 64'(z[0]), 64'd0);
        check("arst_out_valid", 64'(ov[0]), 64'd0);
        check("arst_in_ready", 64'(ir[0]), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(0, 3'd5, 64'h0, 64'h0, 0, 1'b0);
        check("nor_value", res[0], 64'hFFFF_FFFF);

        for (int unsigned k = 0; k < 4; k++) begin
            for (int unsigned o = 0; o < 8; o++) begin
                for (int unsigned i = 0; i < 10; i++) begin
                    do_op(k, 3'(o), {$urandom, $urandom}, {$urandom, $urandom},
                          $urandom_range(0, 2), 1'b0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
